// File: rtl/baud_gen.sv
// baud_gen: SPI serial-clock generator; divides pclk by the baud divisor and
// emits single-cycle sample/launch flags aligned to sclk_o transitions.
// Ports: pclk, preset_n (async, active low), ss_i, spi_mode_i, spiswai_i,
//        sppr_i, spr_i, cpol_i, cpha_i -> sclk_o, four edge flags,
//        baud_rate_divisor_o.
// Option: BAUD_DIV_REG_EN registers the divisor (reset value 2).
module baud_gen #(
    parameter int CNT_W = 12
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             ss_i,
    input  logic [1:0]       spi_mode_i,
    input  logic             spiswai_i,
    input  logic [2:0]       sppr_i,
    input  logic [2:0]       spr_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    output logic             sclk_o,
    output logic             miso_receive_sclk_o,
    output logic             miso_receive_sclk0_o,
    output logic             mosi_send_sclk_o,
    output logic             mosi_send_sclk0_o,
    output logic [CNT_W-1:0] baud_rate_divisor_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic [CNT_W-1:0] div_c;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] half;
    logic             active;
    logic             hit;
    logic             sample_rise;

    // Shift amount widened to 4 bits so spr_i=7 gives 8, not 0.
    always_comb begin
        div_c = ({{(CNT_W-3){1'b0}}, sppr_i} + CNT_W'(1))
                << ({1'b0, spr_i} + 4'd1);
    end

`ifdef BAUD_DIV_REG_EN
    logic [CNT_W-1:0] div_q, div_d;

    always_comb begin
        div_d = div_c;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_q <= CNT_W'(2);
        end else begin
            div_q <= div_d;
        end
    end

    assign div = div_q;
`else
    assign div = div_c;
`endif

    assign half   = div >> 1;
    assign active = !ss_i &&
                    (spi_mode_i == 2'b00 ||
                     (spi_mode_i == 2'b01 && !spiswai_i));

    // Transition cycle: counter at its terminal value while running.
    assign hit = (state_q == RUN) && active &&
                 (cnt_q == half - CNT_W'(1));

    // Sample on the rising sclk edge when cpol == cpha, launch on the other.
    assign sample_rise = (cpol_i == cpha_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        if (!active) begin
            state_d = IDLE;
            cnt_d   = '0;
            sclk_d  = cpol_i;
        end else if (state_q == IDLE) begin
            state_d = RUN;
            cnt_d   = '0;
            sclk_d  = cpol_i;
        end else if (cnt_q >= half - CNT_W'(1)) begin
            // >= so a divisor shrunk mid-transfer toggles next edge
            // instead of wrapping the counter.
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
        end
    end

    assign sclk_o               = sclk_q;
    assign baud_rate_divisor_o  = div;
    assign miso_receive_sclk_o  = hit && !sclk_q &&  sample_rise;
    assign miso_receive_sclk0_o = hit &&  sclk_q && !sample_rise;
    assign mosi_send_sclk_o     = hit && !sclk_q && !sample_rise;
    assign mosi_send_sclk0_o    = hit &&  sclk_q &&  sample_rise;

endmodule

// File: doc/baud_gen.md
# baud_gen

SPI serial-clock generator for the APB SPI master. It sits directly upstream of the shift register. It divides `pclk` by the programmed baud-rate divisor to produce `sclk_o`. It also produces the four single-cycle edge flags that tell the shift register when to sample `miso` and when to launch the next `mosi` bit, so that every shift-register action lands on the same `pclk` edge as the matching `sclk_o` transition.

## Interface
- `CNT_W`, default 12: width of the divisor and of the internal counter. It must hold 2048.
- `pclk`, in, 1: system clock. All state changes on its rising edge.
- `preset_n`, in, 1: asynchronous, active-low reset.
- `ss_i`, in, 1: slave select, active low. Low means a transfer is in progress.
- `spi_mode_i`, in, 2: operating mode. 00 = run, 01 = wait, 1x = stop.
- `spiswai_i`, in, 1: stop the SPI clock while in wait mode.
- `sppr_i`, in, 3: baud prescaler select.
- `spr_i`, in, 3: baud rate select.
- `cpol_i`, in, 1: clock polarity, which is also the idle level of `sclk_o`.
- `cpha_i`, in, 1: clock phase.
- `sclk_o`, out, 1: serial clock.
- `miso_receive_sclk_o`, out, 1: sample `miso` on the coming rising `sclk_o` edge.
- `miso_receive_sclk0_o`, out, 1: sample `miso` on the coming falling `sclk_o` edge.
- `mosi_send_sclk_o`, out, 1: launch `mosi` on the coming rising `sclk_o` edge.
- `mosi_send_sclk0_o`, out, 1: launch `mosi` on the coming falling `sclk_o` edge.
- `baud_rate_divisor_o`, out, `CNT_W`: current divisor.

## Operation
- Divisor = (`sppr_i`+1) × 2^(`spr_i`+1).
  - Range is 2 to 2048.
  - Computed as an unsigned value, zero-extended to `CNT_W`.
  - half = divisor >> 1, range 1 to 1024.
- Active = (`ss_i`==0) and (`spi_mode_i`==00, or (`spi_mode_i`==01 and `spiswai_i`==0)).
- The block has two states:
  - IDLE: `cnt_r`=0 and `sclk_o`=`cpol_i`, registered on each edge.
  - RUN: counting. Entered on the first edge where active=1; left on the first edge where active=0.
- Behaviour in RUN, on each `pclk` edge:
  - If `cnt_r` >= half−1, `sclk_o` toggles and `cnt_r` returns to 0.
  - Otherwise `cnt_r` increments by 1.
  - The >= compare covers a divisor that shrinks mid-transfer: no wrap-around, and the toggle happens on the next edge.
- Sample and launch edges:
  - The sample edge is rising when `cpol_i`==`cpha_i`, and falling otherwise.
  - The launch edge is the opposite edge.
- Edge flags are a combinational decode of registered state and are gated by active:
  - `miso_receive_sclk_o` = RUN & (`cnt_r`==half−1) & `sclk_o`==0 & sample edge rising.
  - `miso_receive_sclk0_o` = RUN & (`cnt_r`==half−1) & `sclk_o`==1 & sample edge falling.
  - `mosi_send_sclk_o` = RUN & (`cnt_r`==half−1) & `sclk_o`==0 & launch edge rising.
  - `mosi_send_sclk0_o` = RUN & (`cnt_r`==half−1) & `sclk_o`==1 & launch edge falling.
  - At most one receive flag and one send flag can be high per cycle, and never both receive flags together.
- The block free-runs while active. Bit and byte counting belong to the downstream shift register and controller.

## Timing
- Reset values: `sclk_o`=0, `cnt_r`=0, state IDLE, all flags 0, `baud_rate_divisor_o`=2 when registered (see Configuration).
- After `preset_n` rises, the first edge loads `sclk_o`=`cpol_i`.
- `ss_i` falls before edge E0; RUN starts at E0 with `cnt_r`=0.
- The first `sclk_o` toggle occurs at edge E0+half.
- The `sclk_o` period is one divisor's worth of `pclk` cycles.
- Each flag is high for exactly the one `pclk` cycle that ends with the matching `sclk_o` transition.
- When `ss_i` rises or a stop/wait condition arises mid-transfer:
  - On the next edge `sclk_o` returns to `cpol_i` and `cnt_r`=0.
  - Flags drop in that same cycle, because they are gated by active.
  - There is no partial-period completion.
- A `cpol_i` or `cpha_i` change in IDLE takes effect on the next edge. A change during RUN is illegal and its behaviour is unspecified.
- Asserting reset mid-transfer forces all outputs to their reset values immediately.

## Configuration
- `BAUD_DIV_REG_EN` defined:
  - The divisor is registered, with reset value 2.
  - A change on `sppr_i`/`spr_i` becomes visible on `baud_rate_divisor_o` and in the counter compare one `pclk` later.
- `BAUD_DIV_REG_EN` undefined:
  - The divisor is combinational from `sppr_i`/`spr_i`.
  - It takes effect in the same cycle.
  - `baud_rate_divisor_o` tracks the inputs even while `preset_n` is low.

## Test plan
- Reset, then sppr=0, spr=0, cpol=0, cpha=0, `ss_i`=0 in run mode -> divisor=2; `sclk_o` toggles every `pclk`; `miso_receive_sclk_o` high before each rise; `mosi_send_sclk0_o` high before each fall.
- sppr=1, spr=0 (divisor 4), cpol=1, cpha=1 -> `sclk_o` idles at 1 and has a 4-pclk period; sampling is on rising edges (`miso_receive_sclk_o`); `mosi_send_sclk0_o` pulses 2 pclk apart from the sample flag.
- sppr=7, spr=7 -> `baud_rate_divisor_o`=2048; first toggle at E0+1024.
- `ss_i` raised after 5 toggles at divisor 8 -> on the next edge `sclk_o`=`cpol_i`, `cnt_r`=0, and no flag pulses afterwards.
- `spi_mode_i`=01 with `spiswai_i`=1 -> `sclk_o` is held at `cpol_i`; after `spiswai_i`=0, counting restarts from 0.
- Divisor changed from 16 to 2 while `cnt_r`=6 -> toggle on the next edge, then period 2, with no counter wrap; with `BAUD_DIV_REG_EN` the change lands one edge later.
